// File: rtl/reg_file_loader_if.sv
// Stream-in and register-bank port bundle for reg_file_loader.
// master: the loader side (accepts words, drives the bank write/read ports).
// slave:  the environment side (word source and register bank).
interface reg_file_loader_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          RegEn;
    logic [AW-1:0] WriteReg;
    logic [DW-1:0] WriteData;
    logic [AW-1:0] ReadReg1;
    logic [DW-1:0] ReadData1;

    modport master (
        input  in_valid, in_data, ReadData1,
        output in_ready, RegEn, WriteReg, WriteData, ReadReg1
    );

    modport slave (
        output in_valid, in_data, ReadData1,
        input  in_ready, RegEn, WriteReg, WriteData, ReadReg1
    );
endinterface

// File: rtl/reg_file_loader.sv
// Streams words into consecutive bank registers, then reads them back through
// read port 1 and compares the additive checksum.
module reg_file_loader #(
    parameter int unsigned DW        = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned NREG      = 32,
    parameter int unsigned FIRST_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AW:0]       count,
    reg_file_loader_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DW-1:0]     checksum
);

    typedef enum logic [2:0] {StIdle, StLoad, StFlush, StVerify, StDone} stateT;

    localparam logic [AW:0]   MaxCnt   = (AW+1)'(NREG - FIRST_REG);
    localparam logic [AW-1:0] FirstIdx = AW'(FIRST_REG);
    localparam logic [AW:0]   CntOne   = (AW+1)'(1);
    localparam logic [AW-1:0] IdxOne   = AW'(1);

    stateT         stateQ, stateD;
    logic [AW:0]   cntQ, cntD;
    logic [AW:0]   kQ, kD;          // write index in LOAD, read counter in VERIFY
    logic [AW:0]   kInc;
    logic          regEnQ, regEnD;
    logic [AW-1:0] writeRegQ, writeRegD;
    logic [DW-1:0] writeDataQ, writeDataD;
    logic [AW-1:0] readReg1Q, readReg1D;
    logic [DW-1:0] sum2Q, sum2D;
    logic [DW-1:0] sumNext;
    logic [DW-1:0] checksumQ, checksumD;
    logic          errorQ, errorD;
    logic          doneQ, doneD;
    logic          busyQ, busyD;

    // Next-state and next-output decode.
    always_comb begin
        stateD     = stateQ;
        cntD       = cntQ;
        kD         = kQ;
        regEnD     = 1'b0;
        writeRegD  = writeRegQ;
        writeDataD = writeDataQ;
        readReg1D  = readReg1Q;
        sum2D      = sum2Q;
        checksumD  = checksumQ;
        errorD     = errorQ;
        doneD      = 1'b0;
        kInc       = kQ + CntOne;
        sumNext    = sum2Q + bus.ReadData1;

        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    checksumD = '0;
                    errorD    = 1'b0;
                    cntD      = count;
                    kD        = '0;
                    if (count == '0) begin
                        stateD = StDone;
                        doneD  = 1'b1;
                    end else if (count > MaxCnt) begin
                        // Would run past the last register: refuse without writing.
                        stateD = StDone;
                        doneD  = 1'b1;
                        errorD = 1'b1;
                    end else begin
                        stateD = StLoad;
                    end
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    regEnD     = 1'b1;
                    writeRegD  = FirstIdx + kQ[AW-1:0];
                    writeDataD = bus.in_data;
                    checksumD  = checksumQ + bus.in_data;
                    kD         = kInc;
                    if (kInc == cntQ) begin
                        stateD = StFlush;
                    end
                end
            end
            StFlush: begin
                // The last word's RegEn is live this cycle; readback starts next.
                readReg1D = FirstIdx;
                sum2D     = '0;
                kD        = '0;
                stateD    = StVerify;
            end
            StVerify: begin
                sum2D = sumNext;
                kD    = kInc;
                if (kInc == cntQ) begin
                    if (sumNext != checksumQ) begin
                        errorD = 1'b1;
                    end
                    doneD  = 1'b1;
                    stateD = StDone;
                end else begin
                    readReg1D = readReg1Q + IdxOne;
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        busyD = (stateD != StIdle);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ     <= StIdle;
            cntQ       <= '0;
            kQ         <= '0;
            regEnQ     <= 1'b0;
            writeRegQ  <= '0;
            writeDataQ <= '0;
            readReg1Q  <= '0;
            sum2Q      <= '0;
            checksumQ  <= '0;
            errorQ     <= 1'b0;
            doneQ      <= 1'b0;
            busyQ      <= 1'b0;
        end else begin
            stateQ     <= stateD;
            cntQ       <= cntD;
            kQ         <= kD;
            regEnQ     <= regEnD;
            writeRegQ  <= writeRegD;
            writeDataQ <= writeDataD;
            readReg1Q  <= readReg1D;
            sum2Q      <= sum2D;
            checksumQ  <= checksumD;
            errorQ     <= errorD;
            doneQ      <= doneD;
            busyQ      <= busyD;
        end
    end

    assign bus.in_ready  = (stateQ == StLoad);
    assign bus.RegEn     = regEnQ;
    assign bus.WriteReg  = writeRegQ;
    assign bus.WriteData = writeDataQ;
    assign bus.ReadReg1  = readReg1Q;
    assign busy          = busyQ;
    assign done          = doneQ;
    assign error         = errorQ;
    assign checksum      = checksumQ;

endmodule

// File: tb/tb_reg_file_loader.sv
// Bench for reg_file_loader: behavioural bank model plus directed and random loads.
module tb_reg_file_loader;

    localparam int MaxLoad = 31;   // NREG - FIRST_REG

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [5:0]  count;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] checksum;

    reg_file_loader_if #(.DW(32), .AW(5)) bus ();

    reg_file_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .count    (count),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .checksum (checksum)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] bank [32];
    bit          corrupt;
    int          presetReq = 0;
    int          presetAck = 0;
    logic [31:0] presetBase;
    logic [31:0] wq[$];
    bit          vpat[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Register bank model: one write port, combinational read port 1.
    always @(posedge clk) begin
        if (presetReq != presetAck) begin
            for (int i = 0; i < 32; i++) bank[i] <= presetBase + 32'(i);
            presetAck <= presetReq;
        end else if (bus.RegEn) begin
            bank[bus.WriteReg] <= bus.WriteData;
        end
    end

    assign bus.ReadData1 = (corrupt && bus.ReadReg1 == 5'd2) ? 32'h0 : bank[bus.ReadReg1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic presetBank(input logic [31:0] base);
        presetBase = base;
        presetReq++;
        @(posedge clk);
        #1;
    endtask

    // One complete operation: start, feed wq (vpat or random bubbles), observe
    // until done, then compare against the reference results.
    task automatic runOp(input string tag, input logic [5:0] n, input int bubblePct,
                         input bit noise);
        int          cyc, acc, lastAcc, doneCyc, pulses, regEnBad, diffs, expDone;
        bit          prevAcc, readySeen, v, busyFirst, inRange, expErr;
        logic        errAtDone;
        logic [31:0] sumAtDone, expSum, readSum;
        logic [31:0] snap [32];

        inRange = (n != 0) && (int'(n) <= MaxLoad);
        for (int i = 0; i < 32; i++) snap[i] = bank[i];
        expSum  = 0;
        readSum = 0;
        if (inRange) begin
            for (int i = 0; i < int'(n); i++) begin
                expSum  += wq[i];
                readSum += (corrupt && i + 1 == 2) ? 32'h0 : wq[i];
            end
        end
        expErr = (int'(n) > MaxLoad) || (readSum != expSum);

        @(negedge clk);
        start        = 1'b1;
        count        = n;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        count = 6'($urandom);

        cyc = 0; acc = 0; lastAcc = 0; doneCyc = -1; pulses = 0; regEnBad = 0;
        prevAcc = 0; readySeen = 0; busyFirst = 0; errAtDone = 0; sumAtDone = 0;
        while (doneCyc < 0 && cyc < 300) begin
            @(negedge clk);
            if (cyc == 0) busyFirst = busy;
            if (bus.RegEn !== prevAcc) regEnBad++;
            if (bus.RegEn === 1'b1) pulses++;
            if (bus.in_ready === 1'b1) readySeen = 1;
            if (done === 1'b1) begin
                doneCyc   = cyc + 1;
                errAtDone = error;
                sumAtDone = checksum;
            end
            v = 0;
            if (bus.in_ready === 1'b1 && acc < int'(n)) begin
                if (vpat.size() > 0) v = vpat.pop_front();
                else v = ($urandom_range(99) >= bubblePct);
            end
            bus.in_valid = v;
            bus.in_data  = v ? wq[acc] : $urandom;
            prevAcc = v;
            if (v) begin
                acc++;
                if (acc == int'(n)) lastAcc = cyc + 1;
            end
            if (noise) begin
                start = $urandom_range(1);
                count = 6'($urandom_range(31, 1));
            end
            @(posedge clk);
            cyc++;
        end

        @(negedge clk);
        start        = 1'b0;
        bus.in_valid = 1'b0;
        expDone = inRange ? lastAcc + int'(n) + 2 : 1;

        check({tag, " busy_after_start"}, 32'(busyFirst), 32'd1);
        check({tag, " done_cycle"}, 32'(doneCyc), 32'(expDone));
        check({tag, " error_at_done"}, 32'(errAtDone), 32'(expErr));
        check({tag, " checksum_at_done"}, sumAtDone, expSum);
        check({tag, " regen_pulses"}, 32'(pulses), inRange ? 32'(n) : 32'd0);
        check({tag, " regen_timing"}, 32'(regEnBad), 32'd0);
        check({tag, " in_ready_seen"}, 32'(readySeen), 32'(inRange));
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " idle_not_busy"}, 32'(busy), 32'd0);
        check({tag, " error_held"}, 32'(error), 32'(expErr));
        check({tag, " checksum_held"}, checksum, expSum);

        diffs = 0;
        for (int r = 0; r < 32; r++) begin
            if (inRange && r >= 1 && r <= int'(n)) begin
                if (bank[r] !== wq[r-1]) diffs++;
            end else if (bank[r] !== snap[r]) begin
                diffs++;
            end
        end
        check({tag, " bank_contents"}, 32'(diffs), 32'd0);
    endtask

    initial begin
        int          hits;
        logic [5:0]  n;

        rst_n        = 1'b0;
        start        = 1'b0;
        count        = '0;
        corrupt      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        presetBank(32'h1000_0000);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst RegEn", 32'(bus.RegEn), 32'd0);
        check("rst WriteReg", 32'(bus.WriteReg), 32'd0);
        check("rst WriteData", bus.WriteData, 32'd0);
        check("rst ReadReg1", 32'(bus.ReadReg1), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst error", 32'(error), 32'd0);
        check("rst checksum", checksum, 32'd0);
        rst_n = 1'b1;

        // Three words, no bubbles.
        wq = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h00000001};
        runOp("basic3", 6'd3, 0, 0);
        check("basic3 known_checksum", checksum, 32'hA9AC79AE);

        // Same words with bubbles.
        presetBank(32'h5555_0000);
        vpat = '{1, 0, 0, 1, 0, 1};
        runOp("bubbles3", 6'd3, 0, 0);
        vpat.delete();

        // Zero-length load.
        runOp("count0", 6'd0, 0, 0);

        // Out-of-range lengths.
        runOp("count32", 6'd32, 0, 0);
        runOp("count63", 6'd63, 0, 0);

        // Full-length load.
        wq.delete();
        for (int i = 0; i < MaxLoad; i++) wq.push_back($urandom);
        runOp("count31", 6'd31, 25, 0);

        // Readback corruption on register 2.
        wq = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h00000001};
        corrupt = 1'b1;
        runOp("corrupt", 6'd3, 0, 0);
        check("corrupt known_checksum", checksum, 32'hA9AC79AE);
        corrupt = 1'b0;

        // Random loads with bubbles and stray start pulses.
        for (int t = 0; t < 6; t++) begin
            n = 6'($urandom_range(MaxLoad, 1));
            wq.delete();
            for (int i = 0; i < int'(n); i++) wq.push_back($urandom);
            runOp("random", n, 40, (t % 2) == 1);
        end

        // Reset after the second accept of a five-word load.
        presetBank(32'h7777_0000);
        @(negedge clk);
        start = 1'b1;
        count = 6'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1111_1111;
        @(negedge clk);
        bus.in_data  = 32'h2222_2222;
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk);
        #1;
        check("midrst in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst RegEn", 32'(bus.RegEn), 32'd0);
        check("midrst WriteReg", 32'(bus.WriteReg), 32'd0);
        check("midrst WriteData", bus.WriteData, 32'd0);
        check("midrst ReadReg1", 32'(bus.ReadReg1), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst checksum", checksum, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hits  = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.RegEn !== 1'b0 || busy !== 1'b0 || done !== 1'b0) hits++;
        end
        check("midrst stays_idle", 32'(hits), 32'd0);
        wq = '{32'h12345678};
        runOp("after_rst", 6'd1, 0, 0);
        check("after_rst reg1", bank[1], 32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
